// File: rtl/sos_pkg.sv
// Shared types and constants for the time-multiplexed biquad sections.
// The default widths below match the cascade's sos_coeff_gain_n_shift instance.
package sos_pkg;

  localparam int SOS_IIR_WD    = 48;
  localparam int SOS_COF_WD    = 32;
  localparam int SOS_SHIFT_NUM = 30;
  localparam int NUM_TAPS      = 5;

  // Coefficient value representing unity gain.
  localparam longint COEF_ONE = longint'(1) << SOS_SHIFT_NUM;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } sos_state_t;

  typedef struct packed {
    logic [SOS_COF_WD-1:0] b0;
    logic [SOS_COF_WD-1:0] b1;
    logic [SOS_COF_WD-1:0] b2;
    logic [SOS_COF_WD-1:0] a1;
    logic [SOS_COF_WD-1:0] a2;
  } sos_coef_t;

  // Feedback taps (a1, a2) come after the three feedforward taps and are subtracted.
  function automatic logic tap_subtracts(input logic [2:0] step);
    return (step >= 3'd3);
  endfunction

endpackage

// File: rtl/sos_biquad_mac_seq.sv
// Direct Form I biquad section that walks its five products through a shared
// external multiplier, one tap per cycle, with valid/ready on both sides.
module sos_biquad_mac_seq
  import sos_pkg::*;
#(
  parameter int IIR_WD    = 48,
  parameter int COF_WD    = 32,
  parameter int SHIFT_NUM = 30
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [IIR_WD-1:0] IN_X,
  input  logic [COF_WD-1:0] B0,
  input  logic [COF_WD-1:0] B1,
  input  logic [COF_WD-1:0] B2,
  input  logic [COF_WD-1:0] A1,
  input  logic [COF_WD-1:0] A2,
  output logic [IIR_WD-1:0] MUL_X,
  output logic [COF_WD-1:0] MUL_H,
  input  logic [IIR_WD-1:0] MUL_P,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [IIR_WD-1:0] OUT_Y
);

  // Scaling lives entirely in the attached multiplier; SHIFT_NUM is carried
  // only so both ends of the MUL_* link are configured from one place.
  if (SHIFT_NUM >= IIR_WD + COF_WD) begin : g_shift_out_of_range
  end

  localparam logic [2:0] LAST_STEP = 3'(NUM_TAPS - 1);

  sos_state_t        r_state;
  sos_state_t        w_state_nxt;
  logic [2:0]        r_step;
  logic              r_in_ready;
  sos_coef_t         r_coef;
  logic [IIR_WD-1:0] r_x;
  logic [IIR_WD-1:0] r_x1;
  logic [IIR_WD-1:0] r_x2;
  logic [IIR_WD-1:0] r_y1;
  logic [IIR_WD-1:0] r_y2;
  logic [IIR_WD-1:0] r_acc;

  logic              w_accept;
  logic              w_out_fire;
  logic              w_sub;
  logic              w_out_valid;
  logic [IIR_WD-1:0] w_mul_x;
  logic [COF_WD-1:0] w_mul_h;

  assign w_accept   = (r_state == IDLE) && r_in_ready && IN_VALID;
  assign w_out_fire = (r_state == OUT) && OUT_READY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mul_x     = '0;
    w_mul_h     = '0;
    w_sub       = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = MAC;
        end
      end
      MAC: begin
        w_sub = tap_subtracts(r_step);
        case (r_step)
          3'd0: begin
            w_mul_x = r_x;
            w_mul_h = r_coef.b0;
          end
          3'd1: begin
            w_mul_x = r_x1;
            w_mul_h = r_coef.b1;
          end
          3'd2: begin
            w_mul_x = r_x2;
            w_mul_h = r_coef.b2;
          end
          3'd3: begin
            w_mul_x = r_y1;
            w_mul_h = r_coef.a1;
          end
          3'd4: begin
            w_mul_x = r_y2;
            w_mul_h = r_coef.a2;
          end
          default: begin
            w_mul_x = '0;
            w_mul_h = '0;
          end
        endcase
        if (r_step == LAST_STEP) begin
          w_state_nxt = OUT;
        end
      end
      OUT: begin
        w_out_valid = 1'b1;
        if (OUT_READY) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Ready is registered so it reads low for the whole reset pulse and rises
  // on the first clock after reset is released.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_in_ready <= 1'b0;
      r_step     <= '0;
      r_coef     <= '0;
      r_x        <= '0;
      r_x1       <= '0;
      r_x2       <= '0;
      r_y1       <= '0;
      r_y2       <= '0;
      r_acc      <= '0;
    end else begin
      r_in_ready <= (w_state_nxt == IDLE);
      if (w_accept) begin
        r_x       <= IN_X;
        r_coef.b0 <= B0;
        r_coef.b1 <= B1;
        r_coef.b2 <= B2;
        r_coef.a1 <= A1;
        r_coef.a2 <= A2;
        r_acc     <= '0;
        r_step    <= '0;
      end
      if (r_state == MAC) begin
        r_acc  <= w_sub ? (r_acc - MUL_P) : (r_acc + MUL_P);
        r_step <= (r_step == LAST_STEP) ? 3'd0 : (r_step + 3'd1);
      end
      if (w_out_fire) begin
        r_x2 <= r_x1;
        r_x1 <= r_x;
        r_y2 <= r_y1;
        r_y1 <= r_acc;
      end
    end
  end

  assign IN_READY  = r_in_ready;
  assign MUL_X     = w_mul_x;
  assign MUL_H     = w_mul_h;
  assign OUT_VALID = w_out_valid;
  assign OUT_Y     = w_out_valid ? r_acc : '0;

endmodule
